load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Bridges the core's memory request port to the banked sram block. Accepts one load/store per
//  valid/ready handshake, drives the sram command/address/data, waits out its one-cycle read
//  latency, zero/sign-extends sub-word loads and returns data or an error on a response port.
// PARAMETERS
//  ADDR_WIDTH     32  request/sram address width
//  COUNTER_WIDTH  32  width of performance counters (used only with LSU_PERF_EN)
// PORTS
//  clock           in   1           single clock, all state on posedge
//  reset_n         in   1           asynchronous, active-low reset
//  req_valid       in   1           request present
//  req_ready       out  1           request accepted when req_valid & req_ready
//  req_write       in   1           1 = store, 0 = load
//  req_size        in   2           0 byte, 1 half, 2 word, 3 illegal
//  req_signed      in   1           loads: sign-extend (1) / zero-extend (0)
//  req_addr        in   ADDR_WIDTH  byte address
//  req_wdata       in   32          store data, right-aligned
//  resp_valid      out  1           response held until resp_ready
//  resp_ready      in   1           response consumed when resp_valid & resp_ready
//  resp_rdata      out  32          extended load data (0 for stores and errors)
//  resp_error      out  2           [0] alignment/illegal size, [1] address out of range
//  sram_command    out  `SRAM_COMMAND_BITS  command to sram
//  sram_addr       out  ADDR_WIDTH  address to sram
//  sram_wdata      out  32          store data to sram (sram shifts into lane itself)
//  sram_rdata      in   32          sram data_out, lane already shifted to bit 0
//  sram_addr_err   in   1           sram address_error (combinational on command/addr)
//  sram_align_err  in   1           sram alignment_error (combinational on command/addr)
// BEHAVIOUR
//  Reset: state IDLE; req_ready 1; resp_valid 0; resp_rdata 0; resp_error 0;
//   sram_command `SRAM_COMMAND_NONE; sram_addr 0; sram_wdata 0; counters 0. Reset mid-access
//   abandons it; a store already issued in ACCESS stays written, nothing is replayed.
//  FSM IDLE -> ACCESS -> (READ_WAIT) -> RESP -> IDLE:
//   IDLE: req_ready=1; on handshake latch write/size/signed/addr/wdata, go ACCESS.
//   ACCESS: drive READ8/16/32 or WRITE8/16/32 from latched size for exactly one cycle. Sample
//    sram_addr_err/sram_align_err this cycle; any error -> RESP with resp_error set, rdata 0
//    (sram suppresses the write). size==3: command stays NONE, resp_error=2'b01, go RESP.
//    Store ok -> RESP. Load ok -> READ_WAIT.
//   READ_WAIT: command NONE; sram_rdata is valid this cycle; format and register into
//    resp_rdata, go RESP.
//   RESP: resp_valid=1, outputs stable; resp_valid & resp_ready -> IDLE next cycle.
//  sram_addr holds the latched address from ACCESS through RESP (sram selects the read bank from
//   the live address, so it must not change during READ_WAIT).
//  Latency from accept edge: store response 2 cycles, load response 3 cycles. req_ready is 0
//   outside IDLE, so no overlap; peak throughput one request per 3 (store) / 4 (load) cycles.
//  Formatting: byte -> sram_rdata[7:0], half -> [15:0], extended per latched signed bit;
//   word -> passthrough; upper garbage bits from sram are always discarded.
// CONFIGURATION
//  LSU_PERF_EN defined: adds outputs perf_loads, perf_stores, perf_errors (COUNTER_WIDTH each),
//   incremented on the RESP handshake by type (errors counted only as errors); wrap on overflow.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  lsu.vh: size encodings, FSM state encodings, resp_error bit positions, `SRAM_COMMAND_NONE
//   guard (reuses sram.vh command encodings).
//  Sub-module load_formatter: combinational size/signed extract-and-extend, unit-testable alone.
// TESTING
//  Store word 0xDEADBEEF @0x10, load word @0x10 -> resp_rdata 0xDEADBEEF, resp_error 0, 4 cycles.
//  Store byte 0x80 @0x13, load signed byte @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080.
//  Load half @0x11 -> resp_error 2'b01, rdata 0; load @ address beyond last bank -> 2'b10.
//  req_size=3 store -> resp_error 2'b01, sram_command never leaves NONE, memory unchanged.
//  Hold resp_ready 0 for 5 cycles -> resp_valid/rdata stable, req_ready 0; then accepts next.
//  Assert reset_n low during READ_WAIT -> next cycle IDLE, resp_valid 0, command NONE.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, response error
// bit positions and the sram command set driven on sram_command.
package load_store_unit_pkg;

  localparam int unsigned SRAM_COMMAND_BITS = 3;

  typedef enum logic [SRAM_COMMAND_BITS-1:0] {
    CMD_NONE    = 3'd0,
    CMD_READ8   = 3'd1,
    CMD_READ16  = 3'd2,
    CMD_READ32  = 3'd3,
    CMD_WRITE8  = 3'd4,
    CMD_WRITE16 = 3'd5,
    CMD_WRITE32 = 3'd6
  } sram_cmd_e;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'd0,
    SIZE_HALF    = 2'd1,
    SIZE_WORD    = 2'd2,
    SIZE_ILLEGAL = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_READ_WAIT,
    ST_RESP
  } lsu_state_e;

  localparam int unsigned ERR_ALIGN_BIT = 0;
  localparam int unsigned ERR_RANGE_BIT = 1;

  // Illegal size maps to CMD_NONE so the sram never sees a request for it.
  function automatic sram_cmd_e access_command(input logic write, input lsu_size_e size);
    sram_cmd_e cmd;
    cmd = CMD_NONE;
    case (size)
      SIZE_BYTE: cmd = write ? CMD_WRITE8  : CMD_READ8;
      SIZE_HALF: cmd = write ? CMD_WRITE16 : CMD_READ16;
      SIZE_WORD: cmd = write ? CMD_WRITE32 : CMD_READ32;
      default:   cmd = CMD_NONE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/load_store_unit_load_formatter.sv
// load_formatter: combinational extract-and-extend of lane-aligned sram read data
// according to access size and signedness.
module load_formatter
  import load_store_unit_pkg::*;
(
  input  lsu_size_e   size,
  input  logic        is_signed,
  input  logic [31:0] raw_data,
  output logic [31:0] data
);

  always_comb begin
    data = '0;
    case (size)
      SIZE_BYTE: data = {{24{is_signed & raw_data[7]}}, raw_data[7:0]};
      SIZE_HALF: data = {{16{is_signed & raw_data[15]}}, raw_data[15:0]};
      SIZE_WORD: data = raw_data;
      default:   data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: bridges the core request port to the banked sram, one access at a time.
// Optional LSU_PERF_EN adds load/store/error performance counters.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [1:0]                   req_size,
  input  logic                         req_signed,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic [31:0]                  req_wdata,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [31:0]                  resp_rdata,
  output logic [1:0]                   resp_error,
  output logic [SRAM_COMMAND_BITS-1:0] sram_command,
  output logic [ADDR_WIDTH-1:0]        sram_addr,
  output logic [31:0]                  sram_wdata,
  input  logic [31:0]                  sram_rdata,
  input  logic                         sram_addr_err,
  input  logic                         sram_align_err
`ifdef LSU_PERF_EN
  ,
  output logic [COUNTER_WIDTH-1:0]     perf_loads,
  output logic [COUNTER_WIDTH-1:0]     perf_stores,
  output logic [COUNTER_WIDTH-1:0]     perf_errors
`endif
);

  lsu_state_e  state_q, state_d;
  logic        write_q;
  lsu_size_e   size_q;
  logic        signed_q;
  logic        req_hs;
  logic        resp_hs;
  logic        access_err;
  logic [31:0] fmt_data;

  assign req_hs  = (state_q == ST_IDLE) && req_valid;
  assign resp_hs = (state_q == ST_RESP) && resp_ready;

  assign access_err = (size_q == SIZE_ILLEGAL) || sram_addr_err || sram_align_err;

  load_formatter u_formatter (
    .size      (size_q),
    .is_signed (signed_q),
    .raw_data  (sram_rdata),
    .data      (fmt_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sram_command = CMD_NONE;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        sram_command = access_command(write_q, size_q);
        if (access_err || write_q) state_d = ST_RESP;
        else                       state_d = ST_READ_WAIT;
      end
      ST_READ_WAIT: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // sram_addr is only reloaded on a new handshake so the read bank select stays put
  // through READ_WAIT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_q    <= 1'b0;
      size_q     <= SIZE_BYTE;
      signed_q   <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      resp_rdata <= '0;
      resp_error <= '0;
    end else begin
      if (req_hs) begin
        write_q    <= req_write;
        size_q     <= lsu_size_e'(req_size);
        signed_q   <= req_signed;
        sram_addr  <= req_addr;
        sram_wdata <= req_wdata;
      end
      if (state_q == ST_ACCESS) begin
        resp_rdata <= '0;
        if (size_q == SIZE_ILLEGAL) begin
          resp_error                <= '0;
          resp_error[ERR_ALIGN_BIT] <= 1'b1;
        end else begin
          resp_error[ERR_ALIGN_BIT] <= sram_align_err;
          resp_error[ERR_RANGE_BIT] <= sram_addr_err;
        end
      end
      if (state_q == ST_READ_WAIT) begin
        resp_rdata <= fmt_data;
        resp_error <= '0;
      end
    end
  end

`ifdef LSU_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_errors <= '0;
    end else if (resp_hs) begin
      if (resp_error != 2'b00) perf_errors <= perf_errors + 1'b1;
      else if (write_q)        perf_stores <= perf_stores + 1'b1;
      else                     perf_loads  <= perf_loads + 1'b1;
    end
  end
`endif

endmodule
